// File: rtl/muldiv_unit.sv
// muldiv_unit: shared multi-cycle RV32M/RV64M multiply/divide unit with start/done
// handshake, hold/flush awareness and a one-entry quotient/remainder cache.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hold,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int N  = XLEN / MUL_BITS;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t state, state_n;

  // Latched request and iteration state
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              neg_p, neg_r;

  // Result cache for DIV-class ops
  logic              cache_valid;
  logic [XLEN-1:0]   cache_a, cache_b, cache_q, cache_r;
  logic              cache_uns;

  // Request decode signals
  logic              is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              zero_b, ovf, special, hit;
  logic [XLEN-1:0]   special_val, hit_val;

  // Iteration step signals
  logic [XLEN+MUL_BITS-1:0] prod_term, partial;
  logic [2*XLEN-1:0]        mul_next, div_next;
  logic [XLEN:0]            diff;

  // Completion signals
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q_fix, r_fix, fix_val;

  // Decode the incoming request: operand signedness, magnitudes, special cases and cache hit
  always_comb begin
    is_div   = op[2];
    a_signed = is_div ? ~op[0] : (op[1] ^ op[0]);
    b_signed = is_div ? ~op[0] : (op[1:0] == 2'b01);
    sa       = a_signed & a[XLEN-1];
    sb       = b_signed & b[XLEN-1];
    abs_a    = sa ? -a : a;
    abs_b    = sb ? -b : b;
    zero_b   = (b == '0);
    ovf      = ~op[0] & (a == MIN_NEG) & (&b);
    special  = is_div & (zero_b | ovf);
    if (zero_b) begin
      special_val = op[1] ? a : '1;
    end else begin
      special_val = op[1] ? '0 : a;
    end
    hit      = is_div & cache_valid & (cache_a == a) & (cache_b == b) & (cache_uns == op[0]);
    hit_val  = op[1] ? cache_r : cache_q;
  end

  // One shift-add multiply step and one restoring divide step on the shared accumulator
  always_comb begin
    prod_term = {{MUL_BITS{1'b0}}, mcand} * {{XLEN{1'b0}}, acc[MUL_BITS-1:0]};
    partial   = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]} + prod_term;
    mul_next  = {partial, acc[XLEN-1:MUL_BITS]};
    diff      = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, mcand};
    if (diff[XLEN]) begin
      div_next = {acc[2*XLEN-2:XLEN], acc[XLEN-1], acc[XLEN-2:0], 1'b0};
    end else begin
      div_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  // Sign correction and result selection at the end of an iterative op
  always_comb begin
    prod  = neg_p ? -acc : acc;
    q_fix = neg_p ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r_fix = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fix_val = op_q[1] ? r_fix : q_fix;
    end else begin
      fix_val = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and status decodes
  always_comb begin
    state_n = state;
    ready   = (state == S_IDLE);
    busy    = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    done    = (state == S_DONE);
    if (hold) begin
      state_n = state;
    end else if (flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (special || hit) begin
              state_n = S_DONE;
            end else if (op[2]) begin
              state_n = S_DIV;
            end else begin
              state_n = S_MUL;
            end
          end
        end
        S_MUL:   if (cnt == CW'(1)) state_n = S_FIX;
        S_DIV:   if (cnt == CW'(1)) state_n = S_FIX;
        S_FIX:   state_n = S_DONE;
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Datapath, result and cache registers; frozen by hold, aborted op leaves res and cache alone
  always_ff @(posedge clk) begin
    if (Rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mcand       <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_p       <= 1'b0;
      neg_r       <= 1'b0;
      res         <= '0;
      cache_valid <= 1'b0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_uns   <= 1'b0;
      cache_q     <= '0;
      cache_r     <= '0;
    end else if (!hold && !flush) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            neg_p <= sa ^ sb;
            neg_r <= sa;
            if (op[2]) begin
              mcand <= abs_b;
              acc   <= {{XLEN{1'b0}}, abs_a};
              cnt   <= CW'(XLEN);
            end else begin
              mcand <= abs_a;
              acc   <= {{XLEN{1'b0}}, abs_b};
              cnt   <= CW'(N);
            end
            if (special) begin
              res <= special_val;
            end else if (hit) begin
              res <= hit_val;
            end
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt - CW'(1);
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          res <= fix_val;
          if (op_q[2]) begin
            cache_valid <= 1'b1;
            cache_a     <= a_q;
            cache_b     <= b_q;
            cache_uns   <= op_q[0];
            cache_q     <= q_fix;
            cache_r     <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard-based bench for muldiv_unit covering multiply, divide,
// cache hits, special cases, hold, flush and mid-op reset.
module tb_muldiv_unit;

  localparam int XLEN     = 32;
  localparam int MUL_BITS = 4;

  logic            clk = 1'b0;
  logic            Rst, start, hold, flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b, res;
  logic            ready, busy, done;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];

  muldiv_unit #(.XLEN(XLEN), .MUL_BITS(MUL_BITS)) dut (
    .clk(clk), .Rst(Rst), .start(start), .op(op), .a(a), .b(b),
    .hold(hold), .flush(flush), .ready(ready), .busy(busy), .done(done), .res(res)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Present a request at a falling edge, record its expectation at the accept edge
  task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input logic [XLEN-1:0] e, input int l);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    lat_q.push_back(l);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Wait (bounded) for done, counting cycles since the accept edge
  task automatic wait_done(input int from, output int lat, output bit busy_seen);
    lat       = from;
    busy_seen = (busy === 1'b1);
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; start = 1'b0; hold = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (res !== '0) begin errors++; $display("[TB] FAIL reset_res: got %h expected 0", res); end
    Rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]      ops [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [XLEN-1:0] as  [4] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [XLEN-1:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h2};
    logic [XLEN-1:0] es  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat, exp_l;
    bit bs_seen;
    logic [XLEN-1:0] exp_r;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], es[i], 10);
      wait_done(1, lat, bs_seen);
      exp_r = exp_q.pop_front();
      exp_l = lat_q.pop_front();
      checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL mul_res[%0d]: got %h expected %h", i, res, exp_r); end
      checks++; if (lat != exp_l) begin errors++; $display("[TB] FAIL mul_lat[%0d]: got %0d expected %0d", i, lat, exp_l); end
      checks++; if (bs_seen !== 1'b1) begin errors++; $display("[TB] FAIL mul_busy[%0d]: got %b expected 1", i, bs_seen); end
      @(negedge clk);
    end
  endtask

  task automatic test_div_cache();
    logic [2:0]      ops [3] = '{3'b100, 3'b110, 3'b111};
    logic [XLEN-1:0] es  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h1};
    int              ls  [3] = '{34, 1, 34};
    int lat, exp_l;
    bit bs_seen;
    logic [XLEN-1:0] exp_r;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'hFFFF_FFF9, 32'h2, es[i], ls[i]);
      wait_done(1, lat, bs_seen);
      exp_r = exp_q.pop_front();
      exp_l = lat_q.pop_front();
      checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL div_res[%0d]: got %h expected %h", i, res, exp_r); end
      checks++; if (lat != exp_l) begin errors++; $display("[TB] FAIL div_lat[%0d]: got %0d expected %0d", i, lat, exp_l); end
      @(negedge clk);
      checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL div_after[%0d]: got ready=%b done=%b expected ready=1 done=0", i, ready, done); end
    end
  endtask

  task automatic test_special();
    logic [2:0]      ops [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [XLEN-1:0] as  [4] = '{32'h5, 32'h5, 32'h8000_0000, 32'h8000_0000};
    logic [XLEN-1:0] bs  [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [XLEN-1:0] es  [4] = '{32'hFFFF_FFFF, 32'h5, 32'h8000_0000, 32'h0};
    int lat, exp_l;
    bit bs_seen;
    logic [XLEN-1:0] exp_r;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], es[i], 1);
      wait_done(1, lat, bs_seen);
      exp_r = exp_q.pop_front();
      exp_l = lat_q.pop_front();
      checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL special_res[%0d]: got %h expected %h", i, res, exp_r); end
      checks++; if (lat != exp_l) begin errors++; $display("[TB] FAIL special_lat[%0d]: got %0d expected %0d", i, lat, exp_l); end
      checks++; if (bs_seen !== 1'b0) begin errors++; $display("[TB] FAIL special_busy[%0d]: got %b expected 0", i, bs_seen); end
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    int lat, exp_l, done_cnt;
    bit bs_seen;
    logic [XLEN-1:0] exp_r;
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 13);
    repeat (2) @(negedge clk);
    hold = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL hold_mid: got busy=%b done=%b expected busy=1 done=0", busy, done); end
    hold = 1'b0;
    wait_done(6, lat, bs_seen);
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    checks++; if (lat != exp_l) begin errors++; $display("[TB] FAIL hold_lat: got %0d expected %0d", lat, exp_l); end
    done_cnt = (done === 1'b1) ? 1 : 0;
    hold = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    hold = 1'b0;
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    checks++; if (done_cnt != 3) begin errors++; $display("[TB] FAIL hold_done_cycles: got %0d expected 3", done_cnt); end
    checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL hold_res: got %h expected %h", res, exp_r); end
  endtask

  task automatic test_flush();
    int lat, exp_l, done_cnt;
    bit bs_seen;
    logic [XLEN-1:0] exp_r;
    issue(3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    exp_q.delete();
    lat_q.delete();
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL flush_state: got ready=%b busy=%b done=%b expected 1 0 0", ready, busy, done); end
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL flush_res: got %h expected fffffffe", res); end
    op = 3'b000; a = 32'h3; b = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_start_ignored: got ready=%b busy=%b expected 1 0", ready, busy); end
    done_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL flush_no_done: got %0d done cycles expected 0", done_cnt); end
    issue(3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34);
    wait_done(1, lat, bs_seen);
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL flush_next_res: got %h expected %h", res, exp_r); end
    checks++; if (lat != exp_l) begin errors++; $display("[TB] FAIL flush_next_lat: got %0d expected %0d", lat, exp_l); end
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int lat, exp_l;
    bit bs_seen;
    logic [XLEN-1:0] exp_r;
    issue(3'b100, 32'd100, 32'd7, 32'd14, 34);
    repeat (19) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst_state: got ready=%b busy=%b done=%b expected 1 0 0", ready, busy, done); end
    checks++; if (res !== '0) begin errors++; $display("[TB] FAIL rst_res: got %h expected 0", res); end
    issue(3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34);
    wait_done(1, lat, bs_seen);
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL rst_next_res: got %h expected %h", res, exp_r); end
    checks++; if (lat != exp_l) begin errors++; $display("[TB] FAIL rst_next_lat: got %0d expected %0d", lat, exp_l); end
    @(negedge clk);
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_mul();
    test_div_cache();
    test_special();
    test_hold();
    test_flush();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
